// File: rtl/ethernet_phy_config.sv
// rtl/ethernet_phy_config.sv - power-up PHY register table writer and host SMI write arbiter
module ethernet_phy_config #(
    parameter logic [23:0] STARTUP_CYCLES = 24'd1_000_000,
    parameter logic [23:0] GAP_CYCLES     = 24'd1_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        restart,
    input  logic        host_req,
    input  logic [4:0]  host_reg,
    input  logic [15:0] host_data,
    output logic        host_ack,
    output logic        smi_init,
    output logic [4:0]  smi_register,
    output logic [15:0] smi_content,
    input  logic        smi_ready,
    output logic        configured,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_ISSUE,
        S_BUSY,
        S_GAP,
        S_IDLE,
        S_H_ISSUE,
        S_H_BUSY
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [23:0] count;
    logic [23:0] count_next;
    logic [1:0]  index;
    logic [1:0]  index_next;
    logic [4:0]  register_next;
    logic [15:0] content_next;
    logic        configured_next;
    logic        host_ack_next;
    logic        restart_pending;
    logic        restart_take;
    logic        advance;
    logic [24:0] count_inc;
    logic        wait_done;
    logic        gap_done;
    logic        gap_zero;

    // PHY register addresses of the power-up table, in write order.
    function automatic logic [4:0] table_reg(input logic [1:0] idx);
        case (idx)
            2'd0:    table_reg = 5'h00;
            2'd1:    table_reg = 5'h04;
            2'd2:    table_reg = 5'h09;
            default: table_reg = 5'h00;
        endcase
    endfunction

    // Data values of the power-up table: soft reset, advertise 10/100,
    // no 1000BASE-T, then autoneg enable + restart.
    function automatic logic [15:0] table_data(input logic [1:0] idx);
        case (idx)
            2'd0:    table_data = 16'h8000;
            2'd1:    table_data = 16'h01E1;
            2'd2:    table_data = 16'h0000;
            default: table_data = 16'h1200;
        endcase
    endfunction

    // A delay of N means N clocks spent in the counting state; the
    // 25-bit compare keeps a zero limit from wrapping into a huge delay.
    assign count_inc = {1'b0, count} + 25'd1;
    assign wait_done = count_inc >= {1'b0, STARTUP_CYCLES};
    assign gap_done  = count_inc >= {1'b0, GAP_CYCLES};
    assign gap_zero  = (GAP_CYCLES == 24'd0);

    assign smi_init = (state == S_ISSUE) || (state == S_H_ISSUE);
    assign busy     = (state != S_IDLE);

    // Next-state, counter, table index and SMI operand selection.
    always_comb begin
        state_next      = state;
        count_next      = count;
        index_next      = index;
        register_next   = smi_register;
        content_next    = smi_content;
        configured_next = configured;
        host_ack_next   = 1'b0;
        restart_take    = 1'b0;
        advance         = 1'b0;

        case (state)
            S_WAIT: begin
                if (wait_done) begin
                    state_next    = S_ISSUE;
                    count_next    = 24'd0;
                    index_next    = 2'd0;
                    register_next = table_reg(2'd0);
                    content_next  = table_data(2'd0);
                end else begin
                    count_next = count_inc[23:0];
                end
            end
            S_ISSUE: begin
                state_next = S_BUSY;
            end
            S_BUSY: begin
                if (smi_ready) begin
                    if (gap_zero) begin
                        advance = 1'b1;
                    end else begin
                        state_next = S_GAP;
                        count_next = 24'd0;
                    end
                end
            end
            S_GAP: begin
                if (gap_done) begin
                    advance = 1'b1;
                end else begin
                    count_next = count_inc[23:0];
                end
            end
            S_IDLE: begin
                if (restart_pending) begin
                    state_next      = S_WAIT;
                    count_next      = 24'd0;
                    configured_next = 1'b0;
                    restart_take    = 1'b1;
                end else if (host_req && !host_ack) begin
                    // host_req is still high during its own ack cycle by
                    // protocol; only a level seen after the ack is new.
                    state_next    = S_H_ISSUE;
                    register_next = host_reg;
                    content_next  = host_data;
                end
            end
            S_H_ISSUE: begin
                state_next = S_H_BUSY;
            end
            S_H_BUSY: begin
                if (smi_ready) begin
                    state_next    = S_IDLE;
                    host_ack_next = 1'b1;
                end
            end
            default: begin
                state_next = S_WAIT;
                count_next = 24'd0;
            end
        endcase

        if (advance) begin
            count_next = 24'd0;
            if (index == 2'd3) begin
                state_next      = S_IDLE;
                configured_next = 1'b1;
            end else begin
                state_next    = S_ISSUE;
                index_next    = index + 2'd1;
                register_next = table_reg(index + 2'd1);
                content_next  = table_data(index + 2'd1);
            end
        end
    end

    // State, counters and registered outputs; restart requests are held
    // until IDLE so an SMI transaction in flight always completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_WAIT;
            count           <= 24'd0;
            index           <= 2'd0;
            smi_register    <= 5'd0;
            smi_content     <= 16'd0;
            host_ack        <= 1'b0;
            configured      <= 1'b0;
            restart_pending <= 1'b0;
        end else begin
            state           <= state_next;
            count           <= count_next;
            index           <= index_next;
            smi_register    <= register_next;
            smi_content     <= content_next;
            host_ack        <= host_ack_next;
            configured      <= configured_next;
            restart_pending <= restart | (restart_pending & ~restart_take);
        end
    end

endmodule

// File: tb/tb_ethernet_phy_config.sv
// tb/tb_ethernet_phy_config.sv - scoreboard bench for ethernet_phy_config
module tb_ethernet_phy_config;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        restart = 1'b0;
    logic        host_req = 1'b0;
    logic [4:0]  host_reg = 5'd0;
    logic [15:0] host_data = 16'd0;
    logic        host_ack;
    logic        smi_init;
    logic [4:0]  smi_register;
    logic [15:0] smi_content;
    logic        smi_ready = 1'b0;
    logic        configured;
    logic        busy;

    ethernet_phy_config #(
        .STARTUP_CYCLES(24'd10),
        .GAP_CYCLES    (24'd3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .restart     (restart),
        .host_req    (host_req),
        .host_reg    (host_reg),
        .host_data   (host_data),
        .host_ack    (host_ack),
        .smi_init    (smi_init),
        .smi_register(smi_register),
        .smi_content (smi_content),
        .smi_ready   (smi_ready),
        .configured  (configured),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  r;
        logic [15:0] d;
    } ent_t;

    ent_t        exp_q[$];
    int          init_cycles[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ready_at = -1;
    int          spurious_at = -1;
    int          last_ready = -100;
    int          ack_count = 0;
    logic        model_busy = 1'b0;
    logic        stable_ok = 1'b1;
    logic        init_prev = 1'b0;
    logic [4:0]  hold_reg = 5'd0;
    logic [15:0] hold_data = 16'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_entry(input logic [4:0] r, input logic [15:0] d);
        ent_t e;
        e.r = r;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic push_table();
        push_entry(5'h00, 16'h8000);
        push_entry(5'h04, 16'h01E1);
        push_entry(5'h09, 16'h0000);
        push_entry(5'h00, 16'h1200);
    endtask

    function automatic int init_at(input int i);
        if (i < init_cycles.size()) return init_cycles[i];
        return -1000;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // SMI master model and output monitor: pops the scoreboard on every
    // init, answers with ready 20 cycles later, watches operand stability.
    always @(negedge clk) begin
        if (reset) begin
            ready_at   = -1;
            model_busy = 1'b0;
            init_prev  = 1'b0;
            smi_ready  = 1'b0;
        end else begin
            if (init_prev) check("init_pulse", 32'(smi_init), 32'd0);
            init_prev = smi_init;
            if (smi_init) begin
                init_cycles.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_init", 32'd1, 32'd0);
                end else begin
                    ent_t e;
                    e = exp_q.pop_front();
                    check("init_reg", 32'(smi_register), 32'(e.r));
                    check("init_data", 32'(smi_content), 32'(e.d));
                end
                hold_reg   = smi_register;
                hold_data  = smi_content;
                stable_ok  = 1'b1;
                model_busy = 1'b1;
                ready_at   = cyc + 20;
            end else if (model_busy && (smi_register !== hold_reg || smi_content !== hold_data)) begin
                stable_ok = 1'b0;
            end
            smi_ready = (cyc == ready_at) || (cyc == spurious_at);
            if (cyc == ready_at) begin
                last_ready = cyc;
                model_busy = 1'b0;
                ready_at   = -1;
                check("smi_stable", 32'(stable_ok), 32'd1);
            end
            if (host_ack) begin
                ack_count++;
                check("ack_latency", 32'(cyc - last_ready), 32'd1);
                check("ack_busy", 32'(busy), 32'd0);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_inits(input int target, input int budget, input string tag);
        int n = 0;
        while (init_cycles.size() < target && n < budget) begin
            step();
            n++;
        end
        if (init_cycles.size() < target) check(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_acks(input int target, input int budget, input string tag);
        int n = 0;
        while (ack_count < target && n < budget) begin
            step();
            n++;
        end
        if (ack_count < target) check(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_configured(output int c, input int budget, input string tag);
        int n = 0;
        c = -1000;
        while (configured !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        if (configured === 1'b1) c = cyc;
        else check(tag, 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_init"}, 32'(smi_init), 32'd0);
        check({tag, "_reg"}, 32'(smi_register), 32'd0);
        check({tag, "_data"}, 32'(smi_content), 32'd0);
        check({tag, "_ack"}, 32'(host_ack), 32'd0);
        check({tag, "_cfg"}, 32'(configured), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic release_reset(output int rel);
        step();
        rel = cyc;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int rel_cyc;
        int conf_cyc;
        int ack_cyc;
        int base;
        int acks;

        // Reset state, then the power-up table with an early host request.
        repeat (3) step();
        check_reset_outputs("rst");
        push_table();
        push_entry(5'h1F, 16'hABCD);
        release_reset(rel_cyc);
        step();
        host_req  = 1'b1;
        host_reg  = 5'h1F;
        host_data = 16'hABCD;
        wait_inits(1, 100, "timeout_first_init");
        spurious_at = init_at(0) + 22;
        wait_configured(conf_cyc, 400, "timeout_cfg1");
        check("cfg_after_ready", 32'(conf_cyc - last_ready), 32'd4);
        check("first_init", 32'(init_at(0) - rel_cyc), 32'd11);
        for (int i = 1; i < 4; i++) check("init_spacing", 32'(init_at(i) - init_at(i - 1)), 32'd24);
        check("early_host_held", 32'(init_cycles.size()), 32'd4);
        wait_acks(1, 100, "timeout_ack1");
        host_req = 1'b0;
        check("host_init_cycle", 32'(init_at(4) - conf_cyc), 32'd1);
        check("q_empty_1", 32'(exp_q.size()), 32'd0);

        // Back-to-back host writes: request held high through the first ack.
        step();
        host_reg  = 5'h05;
        host_data = 16'h1234;
        push_entry(5'h05, 16'h1234);
        push_entry(5'h05, 16'h1234);
        host_req = 1'b1;
        wait_acks(2, 100, "timeout_ack2");
        wait_acks(3, 100, "timeout_ack3");
        host_req = 1'b0;
        check("q_empty_2", 32'(exp_q.size()), 32'd0);

        // Spurious ready while idle.
        repeat (3) step();
        spurious_at = cyc + 1;
        acks = ack_count;
        base = init_cycles.size();
        repeat (5) step();
        check("idle_spur_ack", 32'(ack_count), 32'(acks));
        check("idle_spur_busy", 32'(busy), 32'd0);
        check("idle_spur_init", 32'(init_cycles.size()), 32'(base));

        // Restart during a host write: write completes, then the table re-runs.
        push_entry(5'h0A, 16'h5555);
        host_reg  = 5'h0A;
        host_data = 16'h5555;
        host_req  = 1'b1;
        wait_inits(base + 1, 50, "timeout_host_init3");
        repeat (4) step();
        restart = 1'b1;
        step();
        restart = 1'b0;
        wait_acks(acks + 1, 100, "timeout_ack4");
        ack_cyc  = cyc;
        host_req = 1'b0;
        push_table();
        push_entry(5'h0B, 16'h6666);
        base = init_cycles.size();
        step();
        check("restart_cfg_low", 32'(configured), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        host_reg  = 5'h0B;
        host_data = 16'h6666;
        host_req  = 1'b1;
        wait_configured(conf_cyc, 400, "timeout_cfg2");
        check("restart_first_init", 32'(init_at(base) - ack_cyc), 32'd11);
        check("restart_table_count", 32'(init_cycles.size() - base), 32'd4);
        wait_acks(acks + 2, 100, "timeout_ack5");
        host_req = 1'b0;
        check("q_empty_3", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of the second table entry.
        step();
        restart = 1'b1;
        step();
        restart = 1'b0;
        push_table();
        base = init_cycles.size();
        wait_inits(base + 2, 200, "timeout_mid_init");
        repeat (5) step();
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        ready_at   = -1;
        model_busy = 1'b0;
        exp_q.delete();
        push_table();
        step();
        release_reset(rel_cyc);
        base = init_cycles.size();
        wait_configured(conf_cyc, 400, "timeout_cfg3");
        check("rerst_first_init", 32'(init_at(base) - rel_cyc), 32'd11);
        check("rerst_table_count", 32'(init_cycles.size() - base), 32'd4);
        check("q_empty_4", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ethernet_phy_config.md
# ethernet_phy_config

Configuration sequencer in front of the Ethernet SMI write master. After reset it waits a power-up delay, then writes a fixed four-entry PHY register table through the SMI master, one transaction at a time. It then grants the SMI to a single host write port. It owns the SMI master's `init`/`register`/`content` inputs and consumes its `ready` pulse.

## Interface

- `STARTUP_CYCLES`, default 24'd1_000_000: clocks to wait after reset or restart before the first table write (20 ms at 50 MHz).
- `GAP_CYCLES`, default 24'd1_000: idle clocks inserted after each table write completes, before the next write.

Ports:

- `clk` input 1: clock.
- `reset` input 1: asynchronous, active-high.
- `restart` input 1: single-cycle pulse; re-runs startup delay and table.
- `host_req` input 1: level; host write request.
- `host_reg` input 5: host PHY register address.
- `host_data` input 16: host write data.
- `host_ack` output 1: single-cycle pulse; host write finished.
- `smi_init` output 1: to SMI master `init`; single-cycle pulse.
- `smi_register` output 5: to SMI master `register`.
- `smi_content` output 16: to SMI master `content`.
- `smi_ready` input 1: from SMI master `ready`; single-cycle pulse.
- `configured` output 1: table written; host port open.
- `busy` output 1: high in every state except IDLE.

## Operation

- Table, written in index order 0..3:
  - 0: reg 5'h00, data 16'h8000 (soft reset).
  - 1: reg 5'h04, data 16'h01E1 (advertise 10/100).
  - 2: reg 5'h09, data 16'h0000 (no 1000BASE-T).
  - 3: reg 5'h00, data 16'h1200 (autoneg enable + restart).
- States:
  - WAIT: 24-bit delay counter runs to `STARTUP_CYCLES`, then → ISSUE; index = 0.
  - ISSUE: `smi_init`=1 for exactly one cycle; `smi_register`/`smi_content` = table[index] → BUSY.
  - BUSY: hold; on `smi_ready` → GAP.
  - GAP: count `GAP_CYCLES`, then: index<3 → index+1, ISSUE; index==3 → IDLE, `configured`=1.
  - IDLE: pending restart → WAIT and clear `configured`. Otherwise `host_req`=1 → latch `host_reg`/`host_data` into `smi_register`/`smi_content` → H_ISSUE.
  - H_ISSUE: `smi_init`=1 for one cycle → H_BUSY.
  - H_BUSY: on `smi_ready` → IDLE with `host_ack`=1 for that one cycle.
- `smi_register`/`smi_content` are registered. They are valid in the `smi_init` cycle and stable until `smi_ready`.
- `restart` pulse is latched into `restart_pending` in any state. It is acted on only in IDLE; an SMI transaction is never aborted. Restart has priority over `host_req` in IDLE.
- `host_req` is sampled only in IDLE. It is ignored, not queued, before `configured`; the requester holds it. The requester drops `host_req` in the `host_ack` cycle. If `host_req` is still high in the cycle after `host_ack`, that is a new request.
- `smi_ready` outside BUSY/H_BUSY is ignored.
- Reset values: state WAIT, counter 0, index 0, `smi_init` 0, `smi_register` 0, `smi_content` 0, `host_ack` 0, `configured` 0, `busy` 1, `restart_pending` 0.
- Reset mid-transaction returns the block to WAIT. The SMI master shares the reset, so both restart cleanly.

## Timing

- First `smi_init` is high in the cycle after the `STARTUP_CYCLES`-th rising edge following reset deassertion.
- `smi_ready` high in cycle m:
  - Table write: next `smi_init` is high in cycle m+`GAP_CYCLES`+1, or `configured` rises in cycle m+`GAP_CYCLES`+1 after the last entry.
  - Host write: `host_ack` high and `busy` low in cycle m+1.
- `host_req` seen in IDLE in cycle k → `smi_init` high in cycle k+1.
- Restart pending in IDLE in cycle k → `configured`=0 and `busy`=1 in cycle k+1.
- Counters are 24-bit. A parameter value of 0 gives zero delay (immediate transition).

## Test plan

Bench setup: `STARTUP_CYCLES`=10, `GAP_CYCLES`=3; behavioural SMI model pulses `smi_ready` 20 cycles after `smi_init`.

- Reset release → four `smi_init` pulses carrying (00,8000), (04,01E1), (09,0000), (00,1200) in order. First pulse is 11 cycles after release; pulses are spaced 24 cycles apart; `configured`=1 four cycles after the fourth ready.
- `host_req` during the table sequence with (1F,ABCD) → no `smi_init` for it until `configured`. Then one `smi_init` with 1F/ABCD, and `host_ack` one cycle after ready.
- After `configured`, `host_req` held high through `host_ack` → second transaction starts; two `host_ack` pulses; SMI outputs stable between each init and its ready.
- `restart` pulse during H_BUSY → host write completes with `host_ack`. Then `configured` drops and the full table re-runs with the first init 11 cycles later; `host_req` high at that point is not served.
- `reset` asserted 5 cycles after the second table `smi_init` → all outputs at reset values immediately; sequence restarts from entry 0.
- Spurious `smi_ready` in IDLE and GAP → no state change, no `host_ack`.
